logic_eval_arbiter: RTL and testbench

- Shares one instance of the team's 3-input logic function, x = (A & B) | ~C, between NUM_REQ requesters.
- Each requester offers an operand triple {C,B,A} over a valid/ready handshake. A round-robin arbiter grants one request at a time.
- The block evaluates the granted request in a registered stage and returns the result with the requester ID over a valid/ready response channel.
- It sits between the tile's input decode logic and the output mux, and replaces per-requester copies of the function.

---
 rtl/logic_eval_pkg.sv | 24 ++
 rtl/logic_eval_arbiter_rr_arbiter.sv | 32 +++
 rtl/logic_eval_arbiter.sv | 124 ++++++++++++
 tb/tb_logic_eval_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_eval_pkg.sv
// Shared types and the 3-input logic function x = (A & B) | ~C.
// Used by logic_eval_arbiter; LOGIC_EVAL_SWEEP_EN enables the truth-table sweep.
package logic_eval_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        RESP,
        SWEEP
    } state_t;

    typedef struct packed {
        logic c;
        logic b;
        logic a;
    } operand_t;

    localparam logic [7:0] SWEEP_EXPECT = 8'h8F;

    function automatic logic eval_x(operand_t op);
        return (op.a & op.b) | ~op.c;
    endfunction

endpackage

// File: rtl/logic_eval_arbiter_rr_arbiter.sv
// Round-robin priority pick: first valid index at or above ptr, wrapping.
// Combinational; returns one-hot grant, its index and an any-valid flag.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);

    int j;

    // Walk offsets from farthest to nearest so the nearest valid wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        j     = 0;
        any   = |valid;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (valid[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = W'(j);
            end
        end
    end

endmodule

// File: rtl/logic_eval_arbiter.sv
// Shares one x = (A & B) | ~C evaluator between NUM_REQ requesters.
// Optional macro LOGIC_EVAL_SWEEP_EN adds an 8-code truth-table sweep.
module logic_eval_arbiter
    import logic_eval_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [3*NUM_REQ-1:0] req_operand,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic                 resp_x,
    output logic                 busy
`ifdef LOGIC_EVAL_SWEEP_EN
    ,
    input  logic                 sweep_start,
    output logic                 sweep_done,
    output logic [7:0]           sweep_table
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    state_t             state;
    state_t             next_state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   win_idx;
    logic               any_valid;
    logic               sweep_go;
    logic               accept;
    operand_t           op_q;
    logic [ID_W-1:0]    id_q;

    rr_arbiter #(.N(NUM_REQ), .W(PTR_W)) u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (any_valid)
    );

`ifdef LOGIC_EVAL_SWEEP_EN
    logic [2:0] sweep_idx;
    assign sweep_go = sweep_start;
`else
    assign sweep_go = 1'b0;
`endif

    assign accept = (state == IDLE) && any_valid && !sweep_go;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (sweep_go)       next_state = SWEEP;
                else if (any_valid) next_state = EVAL;
            end
            EVAL: next_state = RESP;
            RESP: if (resp_ready) next_state = IDLE;
`ifdef LOGIC_EVAL_SWEEP_EN
            SWEEP: if (sweep_idx == 3'd7) next_state = IDLE;
`endif
            default: next_state = IDLE;
        endcase
    end

    // req_ready is gated by rst so an asserted reset clears every output.
    always_comb begin
        req_ready  = '0;
        resp_valid = (state == RESP);
        busy       = (state != IDLE);
        if (state == IDLE && !rst && !sweep_go) req_ready = grant;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr  <= '0;
            op_q    <= '0;
            id_q    <= '0;
            resp_x  <= 1'b0;
            resp_id <= '0;
        end else begin
            if (accept) begin
                op_q   <= operand_t'(req_operand[3*int'(win_idx) +: 3]);
                id_q   <= ID_W'(win_idx);
                rr_ptr <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
            end
            if (state == EVAL) begin
                resp_x  <= eval_x(op_q);
                resp_id <= id_q;
            end
        end
    end

`ifdef LOGIC_EVAL_SWEEP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_idx   <= '0;
            sweep_done  <= 1'b0;
            sweep_table <= '0;
        end else begin
            sweep_done <= 1'b0;
            if (state == IDLE && sweep_start) sweep_idx <= '0;
            if (state == SWEEP) begin
                sweep_table[sweep_idx] <= eval_x(operand_t'(sweep_idx));
                sweep_idx              <= sweep_idx + 3'd1;
                if (sweep_idx == 3'd7) sweep_done <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_logic_eval_arbiter.sv
// Scoreboard bench for logic_eval_arbiter (4 requesters).
// Define LOGIC_EVAL_SWEEP_EN to also exercise the sweep.
module tb_logic_eval_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [11:0] req_operand;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic        resp_x;
    logic        busy;
`ifdef LOGIC_EVAL_SWEEP_EN
    logic        sweep_start;
    logic        sweep_done;
    logic [7:0]  sweep_table;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        int   id;
        logic x;
    } exp_t;

    exp_t q[$];
    int   model_ptr = 0;

    always #5 clk = ~clk;

    logic_eval_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_operand (req_operand),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_x      (resp_x),
        .busy        (busy)
`ifdef LOGIC_EVAL_SWEEP_EN
        ,
        .sweep_start (sweep_start),
        .sweep_done  (sweep_done),
        .sweep_table (sweep_table)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_x(input logic [2:0] o);
        return (o[0] & o[1]) | ~o[2];
    endfunction

    // Scoreboard: push on grant, pop on response handshake.
    int         w;
    int         j;
    logic [3:0] exp_oh;
    exp_t       e;
    always @(negedge clk) begin
        if (rst) begin
            model_ptr = 0;
            q.delete();
        end else begin
            if (resp_valid && resp_ready) begin
                if (q.size() == 0) begin
                    check("resp_spurious", resp_valid, 0);
                end else begin
                    e = q.pop_front();
                    check("resp_id", resp_id, e.id);
                    check("resp_x", resp_x, e.x);
                end
            end
            if (|req_ready) begin
                w = -1;
                for (int k = 0; k < 4; k++) begin
                    j = (model_ptr + k) % 4;
                    if (w < 0 && req_valid[j]) w = j;
                end
                exp_oh = (w < 0) ? 4'b0 : 4'(1 << w);
                check("grant", req_ready, exp_oh);
                if (w >= 0) begin
                    e.id = w;
                    e.x  = ref_x(req_operand[3*w +: 3]);
                    q.push_back(e);
                    model_ptr = (w + 1) % 4;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string tag, input int exp_id,
                              input int budget);
        int id;
        id = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (|req_ready) begin
                for (int k = 0; k < 4; k++) if (req_ready[k]) id = k;
                break;
            end
        end
        check(tag, id, exp_id);
    endtask

    task automatic set_op(input int i, input logic [2:0] v);
        req_operand[3*i +: 3] = v;
    endtask

    task automatic single(input logic [2:0] op, input logic x);
        set_op(2, op);
        req_valid = 4'b0100;
        wait_grant("single_grant", 2, 5);
        tick();
        req_valid = 4'b0;
        @(negedge clk);
        check("single_eval_busy", busy, 1);
        check("single_eval_rv", resp_valid, 0);
        @(negedge clk);
        check("single_rv", resp_valid, 1);
        check("single_id", resp_id, 2);
        check("single_x", resp_x, x);
        @(negedge clk);
        check("single_done_rv", resp_valid, 0);
        check("single_done_busy", busy, 0);
        tick();
    endtask

    int gid[5];
    int gcyc[5];
    int n;

    initial begin
        rst         = 1'b1;
        req_valid   = 4'b1111;
        req_operand = 12'b101_100_011_001;
        resp_ready  = 1'b1;
`ifdef LOGIC_EVAL_SWEEP_EN
        sweep_start = 1'b0;
`endif
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_resp_x", resp_x, 0);
        check("rst_busy", busy, 0);
        tick();
        req_valid = 4'b0;
        rst = 1'b0;
        tick();

        single(3'b011, 1'b1);
        single(3'b100, 1'b0);

        // rr_ptr is now 3: requester 0 wins before 1
        set_op(0, 3'b111);
        set_op(1, 3'b010);
        req_valid = 4'b0011;
        wait_grant("wrap_first", 0, 5);
        wait_grant("wrap_second", 1, 8);
        tick();
        req_valid = 4'b0;
        repeat (3) tick();

        // backpressure
        resp_ready = 1'b0;
        set_op(1, 3'b101);
        req_valid = 4'b0010;
        wait_grant("bp_grant", 1, 5);
        tick();
        req_valid = 4'b1111;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_rv", resp_valid, 1);
            check("bp_x", resp_x, 0);
            check("bp_id", resp_id, 1);
            check("bp_ready", req_ready, 0);
        end
        tick();
        resp_ready = 1'b1;
        req_valid  = 4'b0;
        tick();
        @(negedge clk);
        check("bp_after_rv", resp_valid, 0);
        check("bp_after_busy", busy, 0);
        tick();

        // all valid from reset
        rst = 1'b1;
        req_operand = 12'b110_001_111_000;
        req_valid = 4'b1111;
        tick();
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            @(negedge clk);
            if (|req_ready) begin
                for (int k = 0; k < 4; k++) if (req_ready[k]) gid[n] = k;
                gcyc[n] = c;
                n++;
            end
        end
        check("all_count", n, 5);
        for (int i = 0; i < 5; i++) begin
            check("all_order", gid[i], i % 4);
            if (i > 0) check("all_spacing", gcyc[i] - gcyc[i-1], 3);
        end

        // reset during EVAL
        tick();
        req_valid = 4'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rv", resp_valid, 0);
        check("mid_rst_x", resp_x, 0);
        check("mid_rst_id", resp_id, 0);
        check("mid_rst_ready", req_ready, 0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        check("post_rst_rv", resp_valid, 0);
        check("post_rst_grant", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0;
        repeat (4) tick();

`ifdef LOGIC_EVAL_SWEEP_EN
        set_op(1, 3'b011);
        req_valid   = 4'b0010;
        sweep_start = 1'b1;
        @(negedge clk);
        check("sweep_no_ready", req_ready, 0);
        tick();
        sweep_start = 1'b0;
        n = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (sweep_done) begin
                n = c;
                break;
            end
            check("sweep_busy", busy, 1);
        end
        check("sweep_latency", n, 9);
        check("sweep_table", sweep_table, 8'h8F);
        check("sweep_then_grant", req_ready, 4'b0010);
        tick();
        req_valid = 4'b0;
        repeat (4) tick();
`endif

        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        check("drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
